// File: rtl/rca_pkg.sv
// Shared types and constants for the ripple-carry accumulator slice.
package rca_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_SAT_W     = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Saturation limits for a two's complement value of width w (w <= 64),
    // returned zero-extended; callers keep the low w bits.
    function automatic logic [MAX_SAT_W-1:0] SAT_MAX(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_SAT_W-1:0] SAT_MIN(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain WIDTH-bit ripple-carry adder with carry-out and signed-overflow flag.
module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[WIDTH];
    // Same-sign operands producing an opposite-sign result.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/rca_accumulator.sv
// Packet accumulator: sums signed beats through one ripple adder, optional
// saturation, sticky overflow, result presented on a valid/ready handshake.
module rca_accumulator
    import rca_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int COUNT_W  = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_overflow,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [MAX_SAT_W-1:0] SAT_MAX_FULL = SAT_MAX(WIDTH);
    localparam logic [MAX_SAT_W-1:0] SAT_MIN_FULL = SAT_MIN(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_HI       = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_LO       = SAT_MIN_FULL[WIDTH-1:0];

    acc_state_t         state;
    logic [WIDTH-1:0]   acc;
    logic [COUNT_W-1:0] count;
    logic               ovf;

    logic [WIDTH-1:0]   add_sum;
    logic               add_ovf;
    logic               add_cout_unused;

    logic [WIDTH-1:0]   acc_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic               ovf_nxt;
    logic               accept;

    ripple_carry_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a        (acc),
        .b        (in_data),
        .cin      (1'b0),
        .sum      (add_sum),
        .cout     (add_cout_unused),
        .overflow (add_ovf)
    );

    assign accept = in_valid & in_ready;

    // On overflow both operands share acc's sign, so acc's MSB picks the rail.
    always_comb begin
        acc_nxt = add_sum;
        if (SATURATE && add_ovf) begin
            acc_nxt = acc[WIDTH-1] ? SAT_LO : SAT_HI;
        end
    end

    assign ovf_nxt   = ovf | add_ovf;
    assign count_nxt = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_nxt;
                        ovf   <= ovf_nxt;
                        count <= count_nxt;
                        if (in_last) begin
                            state        <= DONE;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            out_sum      <= acc_nxt;
                            out_overflow <= ovf_nxt;
                            out_count    <= count_nxt;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state        <= ACCUM;
                        acc          <= '0;
                        count        <= '0;
                        ovf          <= 1'b0;
                        in_ready     <= 1'b1;
                        out_valid    <= 1'b0;
                        out_sum      <= '0;
                        out_overflow <= 1'b0;
                        out_count    <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/rca_accumulator.md
# rca_accumulator

Sequential accumulation stage downstream of the 32-bit `ripple_carry_adder`. Accepts a packet of signed operands over a valid/ready stream and sums them into a running accumulator through one adder instance. Supports optional saturation and tracks sticky overflow. Presents the packet total, beat count and overflow status on an output valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand and accumulator width (two's complement).
- `COUNT_W`, 8: beat-counter width.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap (raw adder sum).

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  signed operand.
- `in_last`  in  1  final beat of the packet (qualified by the handshake).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  WIDTH  signed packet total.
- `out_overflow`  out  1  sticky: any beat of the packet overflowed.
- `out_count`  out  COUNT_W  number of beats accepted in the packet.

## Operation
- FSM states are `ACCUM` and `DONE`. Reset state is `ACCUM`.
- Reset values: `acc`=0, `count`=0, `ovf`=0, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_overflow`=0, `out_count`=0.
- `ACCUM` state:
  - `in_ready`=1 and `out_valid`=0.
  - An accepted beat (`in_valid & in_ready`) updates three registers:
    - `acc <= f(acc + in_data)`.
    - `ovf <= ovf | adder.overflow`.
    - `count <= count + 1`, saturating at 2^COUNT_W−1.
  - An accepted beat with `in_last`=1 moves the FSM to `DONE`.
  - With `in_valid`=0, all state is held.
- `DONE` state:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`/`out_overflow`/`out_count` equal `acc`/`ovf`/`count` and stay stable until the handshake.
  - On `out_valid & out_ready`: clear `acc`, `count` and `ovf`, then return to `ACCUM`.
- Adder usage:
  - `a`=`acc`, `b`=`in_data`, `cin`=0.
  - The `overflow` output is the signed-overflow indicator: both operands have the same sign and the sum sign differs.
- Saturation `f` when `SATURATE`=1 and overflow:
  - Positive overflow (both operands ≥0) → 2^(WIDTH−1)−1.
  - Negative overflow → −2^(WIDTH−1).
  - Otherwise the raw sum is used.
  - With `SATURATE`=0 the raw (wrapped) sum is always used.
- The sticky `ovf` is set on adder overflow regardless of `SATURATE`.
- A single-beat packet (`in_last` on the first beat) is legal: `out_count`=1 and `out_sum`=`in_data`.
- A zero-beat packet is not possible.

## Timing
- The last beat is accepted at edge N; `out_valid`=1 from the cycle after edge N (1-cycle latency).
- The result is held indefinitely while `out_ready`=0.
- The output handshake completes at edge M. `in_ready`=1 again from the cycle after edge M.
- No beat is accepted in any cycle where `out_valid`=1. Minimum packet period is beats+1 cycles.
- `out_ready` asserted before `out_valid` has no effect.
- The combinational path `acc` → ripple adder → saturation mux → `acc` is the critical path. It must close in one cycle with no pipelining.
- `rst` asserted in any state, including mid-packet or during `DONE` with `out_ready` high, wins on that edge:
  - Registers return to reset values.
  - The partial packet is discarded.
  - No output handshake is counted.
- `in_data` and `in_last` are ignored when `in_valid`=0 or `in_ready`=0.

## Structure
- Shared package `rca_pkg` holds:
  - the state enum `acc_state_t` {`ACCUM`, `DONE`};
  - the default `WIDTH` constant;
  - functions returning the saturation constants `SAT_MAX` and `SAT_MIN` for a given width.
- Sub-module: the existing `ripple_carry_adder`, instantiated once with unchanged ports (`a`, `b`, `cin`, `sum`, `cout`, `overflow`). `cout` is left unused.
- Remaining logic (FSM, counter, sticky flag, saturation mux) is local to `rca_accumulator`.

## Test plan
- Reset and idle: hold `rst` for 2 cycles, then release → `in_ready`=1, `out_valid`=0, all outputs 0.
- Normal packet: beats 100, −50, 12345 (`in_last` on the third) → `out_sum`=12395, `out_count`=3, `out_overflow`=0, `out_valid` one cycle after the last beat.
- Positive saturation (`SATURATE`=1): beats 2147483647, 1, −10 (last) → 2147483637, `out_overflow`=1.
  - Same beats with `SATURATE`=0 → 2147483638, `out_overflow`=1.
- Negative saturation: beats −2147483648, −1 (last) → −2147483648, `out_overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, driving `in_valid`=1 throughout → `in_ready`=0, outputs stable, no beat absorbed.
  - Next packet (single beat 7) → `out_sum`=7, `out_count`=1.
- Mid-packet reset: beats 5, 6, then `rst` for 1 cycle, then beat 9 (last) → `out_sum`=9, `out_count`=1, `out_overflow`=0.
